jpeg_word_packer: RTL and testbench
===================================

Name: jpeg_word_packer

Overview:
- Downstream of the JPEG encoder top, in the ee_clk domain. Consumes the encoder's byte stream and its one-cycle end-of-picture pulse.
- Packs bytes into 32-bit words with byte-keep and end-of-frame marking, buffered in a small FIFO with valid/ready output toward a DMA/bus master.
- Reports per-frame byte length and sticky error flags.

Parameters:
- FIFO_DEPTH, 16, output FIFO depth in words (power of 2, ≥4).
- W_LEN, 24, width of the frame byte counter.

Ports:
- clk  in  1  ee_clk domain clock.
- rstn  in  1  async active-low reset.
- data_valid_i  in  1  byte strobe. No backpressure: every strobe must be consumed.
- data_i  in  8  JPEG byte.
- pic_ready_i  in  1  one-cycle pulse. The current frame is complete; the byte in the same cycle, if any, belongs to it.
- m_valid  out  1  FIFO head valid.
- m_data  out  32  packed word.
- m_keep  out  4  valid byte lanes.
- m_last  out  1  last word of frame.
- m_ready  in  1  sink accepts the head word when m_valid && m_ready.
- frame_len  out  W_LEN  byte count of the completed frame.
- frame_len_valid  out  1  one-cycle pulse with frame_len.
- err_overflow  out  1  sticky: push attempted while FIFO full.
- err_protocol  out  1  sticky: byte arrived during flush.

Behaviour:
- Reset: all outputs 0; lane count 0; held register empty; FIFO empty; state ACC; byte counter 0.
- Byte order: first byte of each word goes in m_data[31:24]. Keep is MSB-aligned: 1 byte = 4'b1000, 2 = 1100, 3 = 1110, 4 = 1111. Unused lanes are zero.
- Holdback: each completed 4-byte word is placed in a one-word held register. The previously held word, if any, is pushed with last=0 at that moment. Holdback lets the final full word carry last=1.
- FSM states:
  - ACC: accept bytes.
  - On pic_ready_i, go to FLUSH_HELD if the held register is full, else FLUSH_PART. If the frame has no bytes and no held word, stay in ACC and only pulse frame_len_valid.
  - FLUSH_HELD: push the held word. last=1 if lane count is 0, else last=0. Next state is FLUSH_PART if lane count ≠ 0, else ACC.
  - FLUSH_PART: push the partial word with last=1 and keep per lane count. Return to ACC.
  - Clear lane count and byte counter when leaving flush.
- Timing:
  - A push decided from inputs sampled at edge E writes the FIFO at edge E+1.
  - m_valid rises after E+1 if the FIFO was empty.
  - A simultaneous push and pop are both honoured.
- frame_len:
  - Counts every accepted byte, including any byte sampled together with pic_ready_i.
  - Latched and pulsed on frame_len_valid in the cycle after pic_ready_i.
  - Wraps modulo 2^W_LEN; no flag on wrap.
- Flush window: upstream guarantees ≥2 idle byte cycles after pic_ready_i. A byte seen in FLUSH_HELD/FLUSH_PART is dropped and sets err_protocol.
- A pic_ready_i seen during flush is ignored.
- Overflow: a push while the FIFO is full (and not popping in the same cycle) drops the word and sets err_overflow. Packing state continues unaffected.
- FIFO output is show-ahead: m_data/m_keep/m_last are stable while m_valid && !m_ready.
- Reset mid-frame discards all partial, held and queued data immediately (async).

Optional Feature:
- Macro JPEG_PACK_BYTESWAP_EN.
- Defined: the first byte goes in m_data[7:0] and keep is LSB-aligned (1 byte = 4'b0001, 3 = 4'b0111).
- Undefined: MSB-first packing as described above. All other behaviour is identical.

Decomposition:
- Shared package jpeg_pack_pkg:
  - lane count constant (4);
  - FSM state encoding ACC/FLUSH_HELD/FLUSH_PART;
  - keep-mask lookup function from lane count;
  - FIFO entry layout {last, keep[3:0], data[31:0]} (37 bits).
- One natural sub-module: jpeg_word_fifo, a single-clock register FIFO with push/pop/full/empty and show-ahead read, parameterised by FIFO_DEPTH.

Test Plan:
- Bytes 01..08, then pic_ready_i, m_ready=1. Expect 0x01020304 keep F last 0; 0x05060708 keep F last 1; frame_len 8 pulsed once.
- Bytes FF D8 FF E0 00, then pic_ready_i. Expect 0xFFD8FFE0 keep F last 0; 0x00000000 keep 1000 last 1; frame_len 5.
- pic_ready_i with no preceding bytes. Expect no words, frame_len_valid with frame_len 0, state stays ACC.
- Byte 0xAB with pic_ready_i in the same cycle, as the 3rd byte after 11 22. Expect 0x1122AB00 keep 1110 last 1; frame_len 3. A byte injected 1 cycle later sets err_protocol=1.
- m_ready=0, 72 bytes (18 words) sent. Expect 16 words queued, 18th held, 17th push dropped, err_overflow=1. Release m_ready: words 1..16 drain in order.
- rstn pulsed low after 6 bytes. Expect all outputs 0, m_valid 0. A new 4-byte frame plus pic_ready_i then yields exactly one word, last=1, frame_len 4.

Source files
------------

// File: rtl/jpeg_pack_pkg.sv
// jpeg_pack_pkg
// Shared definitions for the JPEG word packer:
//   - LANES        : bytes per output word
//   - ST_*         : packer FSM state encoding (ACC / FLUSH_HELD / FLUSH_PART)
//   - fifo_entry_t : FIFO entry layout {last, keep[3:0], data[31:0]}
//   - keep_mask()  : byte-keep mask for a given lane count
//   - place_byte() : writes one byte into its lane of a partially built word
// Build option: JPEG_PACK_BYTESWAP_EN selects LSB-first packing with an
// LSB-aligned keep mask. When it is undefined, packing is MSB-first.
package jpeg_pack_pkg;

    localparam int LANES   = 4;
    localparam int ENTRY_W = 37;

    localparam logic [1:0] ST_ACC        = 2'd0;
    localparam logic [1:0] ST_FLUSH_HELD = 2'd1;
    localparam logic [1:0] ST_FLUSH_PART = 2'd2;

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } fifo_entry_t;

    // Keep mask for n valid bytes (n = 1..4). n = 0 yields an empty mask.
    function automatic logic [3:0] keep_mask(input logic [2:0] n);
        logic [3:0] m;
        m = 4'b0000;
`ifdef JPEG_PACK_BYTESWAP_EN
        case (n)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            3'd4:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
`else
        case (n)
            3'd1:    m = 4'b1000;
            3'd2:    m = 4'b1100;
            3'd3:    m = 4'b1110;
            3'd4:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
`endif
        return m;
    endfunction

    // Place byte b into lane 'lane' of word w (lane 0 = first byte of word).
    function automatic logic [31:0] place_byte(input logic [31:0] w,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  b);
        logic [31:0] r;
        int          idx;
        r = w;
`ifdef JPEG_PACK_BYTESWAP_EN
        idx = int'(lane);
`else
        idx = 3 - int'(lane);
`endif
        r[idx*8 +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/jpeg_word_fifo.sv
// jpeg_word_fifo
// Single-clock register FIFO with show-ahead read.
//   clk, rstn : clock, async active-low reset
//   push      : write wdata (ignored when full unless a pop happens too)
//   wdata     : entry to write
//   pop       : remove head entry (ignored when empty)
//   rdata     : head entry, forced to zero while empty
//   full      : FIFO holds DEPTH entries
//   empty     : FIFO holds no entries
// A push and a pop in the same cycle are both honoured, even when full.
module jpeg_word_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Gate the head so an empty FIFO presents all-zero outputs.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jpeg_word_packer.sv
// jpeg_word_packer
// Packs the JPEG encoder byte stream into 32-bit words with byte-keep and
// end-of-frame marking, queued in a small FIFO toward a bus master. Also
// reports each frame's byte length and sticky error flags.
// Ports:
//   clk, rstn        : ee_clk domain clock, async active-low reset
//   data_valid_i     : byte strobe (no backpressure)
//   data_i           : JPEG byte
//   pic_ready_i      : end-of-frame pulse; a same-cycle byte belongs to the frame
//   m_valid/m_ready  : output handshake
//   m_data/m_keep    : packed word and valid byte lanes
//   m_last           : last word of the frame
//   frame_len        : byte count of the completed frame
//   frame_len_valid  : one-cycle pulse qualifying frame_len
//   err_overflow     : sticky, a word was dropped because the FIFO was full
//   err_protocol     : sticky, a byte arrived during a flush and was dropped
//   dbg_state        : current FSM state (ST_* encoding)
// Build option: JPEG_PACK_BYTESWAP_EN switches to LSB-first packing.
//
// Output handshake: a word transfers on every rising clk edge where m_valid
// and m_ready are both high; while m_valid is high and m_ready low the head
// word (m_data/m_keep/m_last) is held stable; m_valid never depends on m_ready.
module jpeg_word_packer
    import jpeg_pack_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int W_LEN      = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             data_valid_i,
    input  logic [7:0]       data_i,
    input  logic             pic_ready_i,
    output logic             m_valid,
    output logic [31:0]      m_data,
    output logic [3:0]       m_keep,
    output logic             m_last,
    input  logic             m_ready,
    output logic [W_LEN-1:0] frame_len,
    output logic             frame_len_valid,
    output logic             err_overflow,
    output logic             err_protocol,
    output logic [1:0]       dbg_state
);

    logic [1:0]       state,     n_state;
    logic [1:0]       lane_cnt,  n_lane_cnt;
    logic [31:0]      acc_word,  n_acc_word;
    logic             held_v,    n_held_v;
    logic [31:0]      held_word, n_held_word;
    logic [W_LEN-1:0] byte_cnt,  n_byte_cnt;
    logic [W_LEN-1:0] n_frame_len;
    logic             n_frame_len_valid;
    logic             n_proto_err;

    // Push stage: a push decided at edge E lands in the FIFO at edge E+1.
    logic             push_v,     n_push_v;
    fifo_entry_t      push_entry, n_push_entry;

    logic [31:0]      new_word;
    fifo_entry_t      head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             overflow;

    assign new_word = place_byte(acc_word, lane_cnt, data_i);

    always_comb begin
        n_state           = state;
        n_lane_cnt        = lane_cnt;
        n_acc_word        = acc_word;
        n_held_v          = held_v;
        n_held_word       = held_word;
        n_byte_cnt        = byte_cnt;
        n_frame_len       = frame_len;
        n_frame_len_valid = 1'b0;
        n_push_v          = 1'b0;
        n_push_entry      = '0;
        n_proto_err       = 1'b0;

        case (state)
            ST_ACC: begin
                if (data_valid_i) begin
                    n_byte_cnt = byte_cnt + W_LEN'(1);
                    if (lane_cnt == 2'd3) begin
                        // Word complete: it replaces the held word, and the
                        // previous held word leaves as a non-final word.
                        if (held_v) begin
                            n_push_v     = 1'b1;
                            n_push_entry = '{last: 1'b0, keep: 4'hF, data: held_word};
                        end
                        n_held_word = new_word;
                        n_held_v    = 1'b1;
                        n_acc_word  = '0;
                        n_lane_cnt  = 2'd0;
                    end else begin
                        n_acc_word = new_word;
                        n_lane_cnt = lane_cnt + 2'd1;
                    end
                end
                if (pic_ready_i) begin
                    // Decisions use the post-byte view so a same-cycle byte
                    // is part of this frame.
                    n_frame_len       = n_byte_cnt;
                    n_frame_len_valid = 1'b1;
                    n_byte_cnt        = '0;
                    if (n_held_v) begin
                        n_state = ST_FLUSH_HELD;
                    end else if (n_lane_cnt != 2'd0) begin
                        n_state = ST_FLUSH_PART;
                    end
                end
            end

            ST_FLUSH_HELD: begin
                n_push_v     = 1'b1;
                n_push_entry = '{last: (lane_cnt == 2'd0), keep: 4'hF, data: held_word};
                n_held_v     = 1'b0;
                n_state      = (lane_cnt != 2'd0) ? ST_FLUSH_PART : ST_ACC;
            end

            ST_FLUSH_PART: begin
                n_push_v     = 1'b1;
                n_push_entry = '{last: 1'b1, keep: keep_mask({1'b0, lane_cnt}), data: acc_word};
                n_acc_word   = '0;
                n_lane_cnt   = 2'd0;
                n_state      = ST_ACC;
            end

            default: begin
                n_state = ST_ACC;
            end
        endcase

        // Bytes during a flush are dropped; pic_ready_i there is ignored.
        if (data_valid_i && (state != ST_ACC)) begin
            n_proto_err = 1'b1;
        end
    end

    assign pop      = m_valid && m_ready;
    assign overflow = push_v && fifo_full && !pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= ST_ACC;
            lane_cnt        <= 2'd0;
            acc_word        <= '0;
            held_v          <= 1'b0;
            held_word       <= '0;
            byte_cnt        <= '0;
            push_v          <= 1'b0;
            push_entry      <= '0;
            frame_len       <= '0;
            frame_len_valid <= 1'b0;
            err_overflow    <= 1'b0;
            err_protocol    <= 1'b0;
        end else begin
            state           <= n_state;
            lane_cnt        <= n_lane_cnt;
            acc_word        <= n_acc_word;
            held_v          <= n_held_v;
            held_word       <= n_held_word;
            byte_cnt        <= n_byte_cnt;
            push_v          <= n_push_v;
            push_entry      <= n_push_entry;
            frame_len       <= n_frame_len;
            frame_len_valid <= n_frame_len_valid;
            err_overflow    <= err_overflow | overflow;
            err_protocol    <= err_protocol | n_proto_err;
        end
    end

    jpeg_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_v),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_valid   = !fifo_empty;
    assign m_data    = head.data;
    assign m_keep    = head.keep;
    assign m_last    = head.last;
    assign dbg_state = state;

endmodule

// File: tb/tb_jpeg_word_packer.sv
module tb_jpeg_word_packer;
    import jpeg_pack_pkg::*;

    logic        clk;
    logic        rstn;
    logic        data_valid_i;
    logic [7:0]  data_i;
    logic        pic_ready_i;
    logic        m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        m_ready;
    logic [23:0] frame_len;
    logic        frame_len_valid;
    logic        err_overflow;
    logic        err_protocol;
    logic [1:0]  dbg_state;

    jpeg_word_packer #(.FIFO_DEPTH(16), .W_LEN(24)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .data_valid_i    (data_valid_i),
        .data_i          (data_i),
        .pic_ready_i     (pic_ready_i),
        .m_valid         (m_valid),
        .m_data          (m_data),
        .m_keep          (m_keep),
        .m_last          (m_last),
        .m_ready         (m_ready),
        .frame_len       (frame_len),
        .frame_len_valid (frame_len_valid),
        .err_overflow    (err_overflow),
        .err_protocol    (err_protocol),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [36:0] exp_q[$];
    logic [23:0] flen_q[$];
    logic [36:0] model_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    bit          rdy_rand = 0;
    logic        rdy_val  = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: split a frame's bytes into 4-byte words, mark the final one.
    task automatic model_frame(input logic [7:0] b[$]);
        int          n;
        int          nw;
        int          cnt;
        logic [31:0] d;
        logic [3:0]  k;
        logic [3:0]  all_on;
        model_q.delete();
        n      = b.size();
        nw     = (n + 3) / 4;
        all_on = 4'hF;
        for (int w = 0; w < nw; w++) begin
            cnt = (n - 4*w > 4) ? 4 : n - 4*w;
            d   = 32'h0;
            for (int j = 0; j < cnt; j++) begin
`ifdef JPEG_PACK_BYTESWAP_EN
                d = d | (32'(b[4*w+j]) << (8*j));
`else
                d = d | (32'(b[4*w+j]) << (24 - 8*j));
`endif
            end
`ifdef JPEG_PACK_BYTESWAP_EN
            k = all_on >> (4 - cnt);
`else
            k = all_on << (4 - cnt);
`endif
            model_q.push_back({(w == nw - 1), k, d});
        end
    endtask

    task automatic expect_frame(input logic [7:0] b[$]);
        model_frame(b);
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        flen_q.push_back(24'(b.size()));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [7:0] d, input logic p);
        @(posedge clk);
        #1;
        data_valid_i = v;
        data_i       = d;
        pic_ready_i  = p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] b[$], input bit pic_with_last, input bit gaps);
        expect_frame(b);
        for (int i = 0; i < b.size(); i++) begin
            drive(1'b1, b[i], pic_with_last && (i == b.size() - 1));
            if (gaps && i != b.size() - 1 && $urandom_range(0, 2) == 0) idle(1);
        end
        if (!pic_with_last || b.size() == 0) drive(1'b0, 8'h00, 1'b1);
        idle(2 + (gaps ? $urandom_range(0, 3) : 0));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1000 && (exp_q.size() != 0 || flen_q.size() != 0); i++) @(posedge clk);
        check("drain_remaining", 64'(exp_q.size() + flen_q.size()), 64'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_m_valid"},  64'(m_valid), 64'd0);
        check({tag, "_m_data"},   64'(m_data), 64'd0);
        check({tag, "_m_keep"},   64'(m_keep), 64'd0);
        check({tag, "_m_last"},   64'(m_last), 64'd0);
        check({tag, "_flen"},     64'(frame_len), 64'd0);
        check({tag, "_flen_v"},   64'(frame_len_valid), 64'd0);
        check({tag, "_err_ovf"},  64'(err_overflow), 64'd0);
        check({tag, "_err_prot"}, 64'(err_protocol), 64'd0);
        check({tag, "_state"},    64'(dbg_state), 64'(ST_ACC));
    endtask

    // ---------------- ready generator ----------------
    always @(posedge clk) begin
        #1;
        m_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rstn) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("word_unexpected", {27'h0, m_last, m_keep, m_data}, 64'h0);
                else check("word", {27'h0, m_last, m_keep, m_data}, {27'h0, exp_q.pop_front()});
            end
            if (frame_len_valid) begin
                if (flen_q.size() == 0) check("frame_len_unexpected", 64'(frame_len), 64'hFFFF_FFFF);
                else check("frame_len", 64'(frame_len), 64'(flen_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b[$];
        int         len;

        rstn         = 1'b0;
        data_valid_i = 1'b0;
        data_i       = 8'h00;
        pic_ready_i  = 1'b0;
        m_ready      = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Two full words.
        b = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(b, 1'b0, 1'b0);
        // Full word plus one-byte tail.
        b = {8'hFF, 8'hD8, 8'hFF, 8'hE0, 8'h00};
        send_frame(b, 1'b0, 1'b0);
        wait_drain();

        // Empty frame: only a frame_len pulse of 0, FSM stays in ACC.
        b.delete();
        expect_frame(b);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        check("empty_frame_state", 64'(dbg_state), 64'(ST_ACC));
        check("empty_frame_no_word", 64'(m_valid), 64'd0);
        idle(2);
        wait_drain();

        // Randomized frames with random sink backpressure.
        rdy_rand = 1;
        for (int f = 0; f < 30; f++) begin
            b.delete();
            len = $urandom_range(0, 14);
            for (int i = 0; i < len; i++) b.push_back(8'($urandom_range(0, 255)));
            send_frame(b, $urandom_range(0, 1) == 1, 1'b1);
        end
        wait_drain();
        rdy_rand = 0;
        rdy_val  = 1'b1;
        check("rand_err_overflow", 64'(err_overflow), 64'd0);
        check("rand_err_protocol", 64'(err_protocol), 64'd0);

        // Byte with pic_ready_i, then a byte inside the flush window.
        b = {8'h11, 8'h22, 8'hAB};
        expect_frame(b);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'hAB, 1'b1);
        drive(1'b1, 8'hCD, 1'b0);
        idle(3);
        check("protocol_err_set", 64'(err_protocol), 64'd1);
        wait_drain();

        // Overflow: 18 words with sink stalled; word 17 is dropped.
        rdy_val = 1'b0;
        idle(1);
        b.delete();
        for (int i = 0; i < 72; i++) b.push_back(8'($urandom_range(0, 255)));
        model_frame(b);
        for (int i = 0; i < 16; i++) exp_q.push_back(model_q[i]);
        for (int i = 0; i < 72; i++) drive(1'b1, b[i], 1'b0);
        idle(3);
        check("overflow_err_set", 64'(err_overflow), 64'd1);
        check("overflow_m_valid", 64'(m_valid), 64'd1);
        rdy_val = 1'b1;
        wait_drain();
        // Closing the frame releases the held 18th word as the last one.
        exp_q.push_back(model_q[17]);
        flen_q.push_back(24'd72);
        drive(1'b0, 8'h00, 1'b1);
        idle(3);
        wait_drain();

        // Reset mid-frame discards everything.
        for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h30 + i), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check_zero_outputs("midreset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        b = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
        send_frame(b, 1'b0, 1'b0);
        wait_drain();
        idle(4);
        check("final_m_valid", 64'(m_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
